// File: rtl/mdio_arbiter.sv
// mdio_arbiter: round-robin sharing of one Clause 22 MDIO master between NREQ requesters.
// Optional MDIO_TIMEOUT_EN aborts a transaction after TIMEOUT_CYC cycles in WAIT with err.
module mdio_arbiter #(
   parameter int NREQ        = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_wr,
   input  logic [5*NREQ-1:0]  req_phy,
   input  logic [5*NREQ-1:0]  req_reg,
   input  logic [16*NREQ-1:0] req_wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    ack,
   output logic [15:0]        rdata,
   output logic               err,
   output logic               busy,
   output logic               mst_start,
   output logic [31:0]        mst_frame,
   input  logic               mst_done,
   input  logic [15:0]        mst_rd_data
);
   localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
   localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, RESP = 2'd3;

   if (NREQ < 1 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("mdio_arbiter: parameter out of range");
   end

   logic [1:0]    state;
   logic [IW-1:0] owner, last, win, cand;
   logic          found, wr_q;

   // First requesting index after the last winner, wrapping modulo NREQ
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IW'((int'(last) + k) % NREQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign busy      = state != IDLE;
   assign mst_start = state == LAUNCH;
   assign gnt       = busy ? NREQ'(1) << owner : '0;
   assign ack       = (state == RESP) ? NREQ'(1) << owner : '0;

`ifdef MDIO_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] cnt;
   logic          to_q;
   assign err = (state == RESP) & to_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         owner     <= '0;
         last      <= IW'(NREQ - 1);
         wr_q      <= 1'b0;
         mst_frame <= '0;
         rdata     <= '0;
`ifdef MDIO_TIMEOUT_EN
         cnt       <= '0;
         to_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (found) begin
               owner     <= win;
               wr_q      <= req_wr[win];
               mst_frame <= req_wr[win]
                  ? {4'b0101, req_phy[5*win +: 5], req_reg[5*win +: 5], 2'b10, req_wdata[16*win +: 16]}
                  : {4'b0110, req_phy[5*win +: 5], req_reg[5*win +: 5], 2'b00, 16'h0000};
               state     <= LAUNCH;
            end
            LAUNCH: begin
               state <= WAIT;
`ifdef MDIO_TIMEOUT_EN
               cnt   <= '0;
               to_q  <= 1'b0;
`endif
            end
            WAIT: begin
               if (mst_done) begin
                  if (!wr_q) rdata <= mst_rd_data;
                  state <= RESP;
               end
`ifdef MDIO_TIMEOUT_EN
               else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                  if (!wr_q) rdata <= 16'hFFFF;
                  to_q  <= 1'b1;
                  state <= RESP;
               end else cnt <= cnt + 1'b1;
`endif
            end
            RESP: begin
               last  <= owner;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mdio_arbiter.sv
// tb_mdio_arbiter: directed and randomized checks of mdio_arbiter against a round-robin model.
module tb_mdio_arbiter;
   localparam int N = 2;
   logic clk = 1'b0, reset = 1'b0;
   logic [N-1:0] req = '0, gnt, ack;
   logic [15:0] rdata, mst_rd_data = '0;
   logic err, busy, mst_start, mst_done = 1'b0;
   logic [31:0] mst_frame;
   logic wr_f [N];
   logic [4:0] phy_f [N], reg_f [N];
   logic [15:0] wd_f [N];
   logic [N-1:0] req_wr;
   logic [5*N-1:0] req_phy, req_reg;
   logic [16*N-1:0] req_wdata;
   int n_chk = 0, n_fail = 0, last_m = N - 1, w;
   logic [15:0] rdata_m = '0;

   assign req_wr    = {wr_f[1], wr_f[0]};
   assign req_phy   = {phy_f[1], phy_f[0]};
   assign req_reg   = {reg_f[1], reg_f[0]};
   assign req_wdata = {wd_f[1], wd_f[0]};

   always #5 clk = ~clk;

   mdio_arbiter #(.NREQ(N), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_phy(req_phy),
      .req_reg(req_reg), .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .rdata(rdata),
      .err(err), .busy(busy), .mst_start(mst_start), .mst_frame(mst_frame),
      .mst_done(mst_done), .mst_rd_data(mst_rd_data));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] frame_of(input int i);
      return wr_f[i] ? {2'b01, 2'b01, phy_f[i], reg_f[i], 2'b10, wd_f[i]}
                     : {2'b01, 2'b10, phy_f[i], reg_f[i], 2'b00, 16'h0000};
   endfunction

   // Winner = requester with the smallest forward distance past the previous winner
   function automatic int pick(input logic [N-1:0] m, input int lst);
      int best = -1, bd = N + 1;
      for (int i = 0; i < N; i++)
         if (m[i] && ((i - lst - 1 + 2 * N) % N) < bd) begin
            bd   = (i - lst - 1 + 2 * N) % N;
            best = i;
         end
      return best;
   endfunction

   task automatic raise(input int i, input logic wr, input logic [4:0] p, input logic [4:0] r, input logic [15:0] d);
      wr_f[i] = wr; phy_f[i] = p; reg_f[i] = r; wd_f[i] = d;
      req[i] = 1'b1;
   endtask

   // Called at an IDLE negedge with requests already raised; plays the master side
   task automatic serve(input int delay, input logic [15:0] rd, input bit drop_early, output int win);
      int waits = 0;
      win = pick(req, last_m);
      while (mst_start !== 1'b1 && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      chk("start_latency", waits, 1);
      chk("gnt_launch", gnt, N'(1) << win);
      chk("frame", mst_frame, frame_of(win));
      chk("busy", busy, 1);
      if (drop_early) req[win] = 1'b0;
      @(negedge clk);
      chk("start_pulse_one_cycle", mst_start, 0);
      repeat (delay) @(negedge clk);
      mst_done = 1'b1;
      mst_rd_data = rd;
      @(negedge clk);
      mst_done = 1'b0;
      if (!wr_f[win]) rdata_m = rd;
      chk("ack", ack, N'(1) << win);
      chk("err", err, 0);
      chk("rdata", rdata, rdata_m);
      req[win] = 1'b0;
      @(negedge clk);
      chk("idle_after_resp", {ack, gnt, busy}, 0);
      last_m = win;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         wr_f[i] = 1'b0; phy_f[i] = '0; reg_f[i] = '0; wd_f[i] = '0;
      end
      #12;
      chk("reset_outputs", {gnt, ack, err, busy, mst_start, mst_frame, rdata}, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      raise(0, 1'b1, 5'd1, 5'd5, 16'hABCD);
      serve(64, 16'h1234, 0, w);
      chk("write_frame_const", mst_frame, 32'h5096ABCD);
      chk("write_winner", w, 0);
      raise(1, 1'b0, 5'd2, 5'd8, 16'h5555);
      serve(10, 16'hFEED, 0, w);
      chk("read_frame_const", mst_frame, 32'h61200000);
      chk("read_rdata_const", rdata, 16'hFEED);
      raise(0, 1'b0, 5'd3, 5'd1, 16'h0);
      serve(5, 16'hBEEF, 1, w);
      @(negedge clk);
      chk("withdraw_no_regrant", {gnt, mst_start}, 0);
      raise(0, 1'b0, 5'd4, 5'd2, 16'h0);
      @(negedge clk);
      @(negedge clk);
      chk("reset_test_in_wait", {busy, mst_start}, 2'b10);
      #2 reset = 1'b0;
      #1 chk("async_reset_outputs", {gnt, ack, err, busy, mst_start, mst_frame, rdata}, 0);
      req = '0;
      raise(1, 1'b1, 5'd7, 5'd9, 16'h0F0F);
      last_m = N - 1;
      rdata_m = '0;
      @(negedge clk);
      reset = 1'b1;
      serve(3, 16'h0, 0, w);
      chk("post_reset_req1", w, 1);
      raise(0, 1'b1, 5'd10, 5'd11, 16'h1111);
      raise(1, 1'b0, 5'd12, 5'd13, 16'h0);
      serve(2, 16'hAAAA, 0, w);
      chk("contention_first", w, 0);
      serve(2, 16'h5A5A, 0, w);
      chk("contention_second", w, 1);
      raise(0, 1'b0, 5'd14, 5'd15, 16'h0);
      raise(1, 1'b1, 5'd16, 5'd17, 16'h2222);
      serve(1, 16'h7777, 0, w);
      chk("recontention_first", w, 0);
      serve(1, 16'h8888, 0, w);
      chk("recontention_second", w, 1);
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < N; i++)
            if (!req[i] && $urandom_range(0, 1) == 1)
               raise(i, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
         if (req == '0) raise($urandom_range(0, N - 1), 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
         serve($urandom_range(0, 8), 16'($urandom), 0, w);
      end
`ifdef MDIO_TIMEOUT_EN
      raise(0, 1'b0, 5'd1, 5'd2, 16'h0);
      @(negedge clk);
      chk("to_launch", mst_start, 1);
      repeat (16) @(negedge clk);
      chk("to_not_early", ack, 0);
      @(negedge clk);
      chk("to_ack", ack, 2'b01);
      chk("to_err", err, 1);
      chk("to_rdata", rdata, 16'hFFFF);
      req[0] = 1'b0;
      @(negedge clk);
      chk("to_err_one_cycle", {ack, err}, 0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
